// File: rtl/cjb_risc_cu_pkg.sv
// Shared encodings for the HMMIOP RISC control unit: opcodes, FSM states,
// internal-bus select codes, jump condition codes and the ALU function map.
package cjb_risc_cu_pkg;

  // state   | meaning
  // S_RST   | hold PC in reset, then start fetching
  // S_FETCH | load IR, advance PC, sample input port
  // S_DECODE| execute one-word ops, or latch base/index for two-word ops
  // S_ADDR  | load MAR with the effective address
  // S_MEM   | data memory / I/O access or PC load for a taken jump
  // S_HALT  | idle until reset
  typedef enum logic [2:0] {
    S_RST    = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_ADDR   = 3'b011,
    S_MEM    = 3'b100,
    S_HALT   = 3'b101
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_POP  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_ADDK = 4'hC;
  localparam logic [3:0] OP_JUMP = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // IB2 source: IB0 passthrough, ALU result, data memory, IPDR/stack mux
  localparam logic [1:0] IB2_IB0   = 2'b00;
  localparam logic [1:0] IB2_ALU   = 2'b01;
  localparam logic [1:0] IB2_DM    = 2'b10;
  localparam logic [1:0] IB2_IPSTK = 2'b11;

  localparam logic [3:0] CC_ALWAYS = 4'h0;
  localparam logic [3:0] CC_C      = 4'h1;
  localparam logic [3:0] CC_N      = 4'h2;
  localparam logic [3:0] CC_V      = 4'h3;
  localparam logic [3:0] CC_Z      = 4'h4;
  localparam logic [3:0] CC_NC     = 4'h5;
  localparam logic [3:0] CC_NN     = 4'h6;
  localparam logic [3:0] CC_NV     = 4'h7;
  localparam logic [3:0] CC_NZ     = 4'h8;

  localparam logic [3:0] FS_ADD  = 4'b0000;
  localparam logic [3:0] FS_SUB  = 4'b0001;
  localparam logic [3:0] FS_AND  = 4'b0100;
  localparam logic [3:0] FS_OR   = 4'b0101;
  localparam logic [3:0] FS_XOR  = 4'b0110;
  localparam logic [3:0] FS_NOT  = 4'b0111;
  localparam logic [3:0] FS_ADDK = 4'b1000;

  // Opcode to ALU function; non-ALU opcodes map to ADD (value is don't-care)
  function automatic logic [3:0] alu_fs(input logic [3:0] op);
    logic [3:0] fs;
    fs = FS_ADD;
    case (op)
      OP_SUB:  fs = FS_SUB;
      OP_AND:  fs = FS_AND;
      OP_OR:   fs = FS_OR;
      OP_XOR:  fs = FS_XOR;
      OP_NOT:  fs = FS_NOT;
      OP_ADDK: fs = FS_ADDK;
      default: fs = FS_ADD;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/cjb_cond_eval_v.sv
// Jump condition evaluator: decodes the low nibble of a JUMP instruction
// against the {C,N,V,Z} status flags. Codes 9..15 are never taken.
module cjb_cond_eval_v
  import cjb_risc_cu_pkg::*;
(
  input  logic [3:0] iw_lo_i,
  input  logic [3:0] sr_cnvz_i,
  output logic       take_o
);

  logic flag_c, flag_n, flag_v, flag_z;

  assign flag_c = sr_cnvz_i[3];
  assign flag_n = sr_cnvz_i[2];
  assign flag_v = sr_cnvz_i[1];
  assign flag_z = sr_cnvz_i[0];

  // Select the flag (or its complement) named by the condition code
  always_comb begin
    take_o = 1'b0;
    case (iw_lo_i)
      CC_ALWAYS: take_o = 1'b1;
      CC_C:      take_o = flag_c;
      CC_N:      take_o = flag_n;
      CC_V:      take_o = flag_v;
      CC_Z:      take_o = flag_z;
      CC_NC:     take_o = ~flag_c;
      CC_NN:     take_o = ~flag_n;
      CC_NV:     take_o = ~flag_v;
      CC_NZ:     take_o = ~flag_z;
      default:   take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cjb_risc_hmmiop_cu_v.sv
// Control unit for the 8-bit Harvard memory-mapped-I/O RISC core.
// Moore sequencer: outputs decode from the registered state plus the
// instruction word, flags and MAR held steady by the data path.
module cjb_risc_hmmiop_cu_v
  import cjb_risc_cu_pkg::*;
#(
  parameter logic [9:0] IO_ADDR = 10'h3FF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] IW,
  input  logic [3:0] SR_CNVZ,
  input  logic [9:0] MARout,
  output logic       RST_PC,
  output logic       LD_PC,
  output logic       CNT_PC,
  output logic       LD_IR,
  output logic       LD_R0,
  output logic       LD_R1,
  output logic       LD_R2,
  output logic       LD_R3,
  output logic       LD_SR,
  output logic       LD_MABR,
  output logic       LD_MAXR,
  output logic       LD_MAR,
  output logic       RW,
  output logic       LD_IPDR,
  output logic       LD_OPDR,
  output logic [1:0] IB0_SEL,
  output logic [1:0] IB1_SEL,
  output logic [1:0] IB2_SEL,
  output logic [3:0] ALU_FS,
  output logic       push,
  output logic       pop,
  output logic       ipstksel,
  output logic [2:0] STATE
);

  state_e     state_q;
  logic [3:0] opcode;
  logic [1:0] ri;
  logic [1:0] rj;
  logic [3:0] ri_hot;
  logic [3:0] ld_r;
  logic       two_word;
  logic       io_hit;
  logic       jump_take;

  assign opcode   = IW[7:4];
  assign ri       = IW[3:2];
  assign rj       = IW[1:0];
  assign ri_hot   = 4'b0001 << ri;
  assign two_word = (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_JUMP);
  assign io_hit   = (MARout == IO_ADDR);

  cjb_cond_eval_v u_cond (
    .iw_lo_i   (IW[3:0]),
    .sr_cnvz_i (SR_CNVZ),
    .take_o    (jump_take)
  );

  // State register with synchronous reset; reset wins over any in-flight instruction
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RST;
    end else begin
      case (state_q)
        S_RST:    state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_HALT)  state_q <= S_HALT;
          else if (two_word)      state_q <= S_ADDR;
          else                    state_q <= S_FETCH;
        end
        // An untaken jump has nothing to do in the memory phase
        S_ADDR: begin
          if ((opcode == OP_JUMP) && !jump_take) state_q <= S_FETCH;
          else                                   state_q <= S_MEM;
        end
        S_MEM:    state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_RST;
      endcase
    end
  end

  // Control-line decode from current state and instruction fields
  always_comb begin
    RST_PC   = 1'b0;
    LD_PC    = 1'b0;
    CNT_PC   = 1'b0;
    LD_IR    = 1'b0;
    ld_r     = 4'b0000;
    LD_SR    = 1'b0;
    LD_MABR  = 1'b0;
    LD_MAXR  = 1'b0;
    LD_MAR   = 1'b0;
    RW       = 1'b1;
    LD_IPDR  = 1'b0;
    LD_OPDR  = 1'b0;
    IB0_SEL  = 2'b00;
    IB1_SEL  = 2'b00;
    IB2_SEL  = IB2_IB0;
    ALU_FS   = 4'b0000;
    push     = 1'b0;
    pop      = 1'b0;
    ipstksel = 1'b0;
    case (state_q)
      S_RST: RST_PC = 1'b1;
      S_FETCH: begin
        LD_IR   = 1'b1;
        CNT_PC  = 1'b1;
        LD_IPDR = 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          OP_MOV: begin
            IB0_SEL = rj;
            IB2_SEL = IB2_IB0;
            ld_r    = ri_hot;
          end
          OP_PUSH: begin
            IB0_SEL = ri;
            IB2_SEL = IB2_IB0;
            push    = 1'b1;
          end
          OP_POP: begin
            pop      = 1'b1;
            ipstksel = 1'b1;
            IB2_SEL  = IB2_IPSTK;
            ld_r     = ri_hot;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDK: begin
            IB0_SEL = ri;
            IB1_SEL = rj;
            IB2_SEL = IB2_ALU;
            ld_r    = ri_hot;
            LD_SR   = 1'b1;
            ALU_FS  = alu_fs(opcode);
          end
          // Two-word ops: latch base/index and step PC past the offset byte
          OP_LD, OP_ST, OP_JUMP: begin
            LD_MABR = 1'b1;
            LD_MAXR = 1'b1;
            CNT_PC  = 1'b1;
            IB0_SEL = rj;
            IB2_SEL = IB2_IB0;
          end
          default: ;
        endcase
      end
      S_ADDR: LD_MAR = 1'b1;
      S_MEM: begin
        case (opcode)
          OP_LD: begin
            ld_r = ri_hot;
            if (io_hit) begin
              IB2_SEL  = IB2_IPSTK;
              ipstksel = 1'b0;
            end else begin
              IB2_SEL = IB2_DM;
            end
          end
          // Stores to the I/O address go to OPDR, never to data memory
          OP_ST: begin
            IB0_SEL = ri;
            IB2_SEL = IB2_IB0;
            if (io_hit) LD_OPDR = 1'b1;
            else        RW      = 1'b0;
          end
          OP_JUMP: LD_PC = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign LD_R0 = ld_r[0];
  assign LD_R1 = ld_r[1];
  assign LD_R2 = ld_r[2];
  assign LD_R3 = ld_r[3];
  assign STATE = state_q;

endmodule

// File: tb/tb_cjb_risc_hmmiop_cu_v.sv
// Bench for the HMMIOP control unit: directed cases followed by random
// instructions, each expanded by a reference model into its expected
// per-cycle control words.
module tb_cjb_risc_hmmiop_cu_v;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] IW;
  logic [3:0] SR_CNVZ;
  logic [9:0] MARout;
  logic RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3;
  logic LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR;
  logic [1:0] IB0_SEL, IB1_SEL, IB2_SEL;
  logic [3:0] ALU_FS;
  logic push, pop, ipstksel;
  logic [2:0] STATE;

  cjb_risc_hmmiop_cu_v #(.IO_ADDR(10'h3FF)) dut (
    .Clock(Clock), .Reset(Reset), .IW(IW), .SR_CNVZ(SR_CNVZ), .MARout(MARout),
    .RST_PC(RST_PC), .LD_PC(LD_PC), .CNT_PC(CNT_PC), .LD_IR(LD_IR),
    .LD_R0(LD_R0), .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3),
    .LD_SR(LD_SR), .LD_MABR(LD_MABR), .LD_MAXR(LD_MAXR), .LD_MAR(LD_MAR),
    .RW(RW), .LD_IPDR(LD_IPDR), .LD_OPDR(LD_OPDR),
    .IB0_SEL(IB0_SEL), .IB1_SEL(IB1_SEL), .IB2_SEL(IB2_SEL), .ALU_FS(ALU_FS),
    .push(push), .pop(pop), .ipstksel(ipstksel), .STATE(STATE)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] st;
    logic       rst_pc, ld_pc, cnt_pc, ld_ir;
    logic [3:0] ld_r;
    logic       ld_sr, ld_mabr, ld_maxr, ld_mar, rw, ld_ipdr, ld_opdr;
    logic [1:0] ib0, ib1, ib2;
    logic [3:0] fs;
    logic       push, pop, ipstk;
  } cyc_t;

  localparam logic [9:0] IO_A = 10'h3FF;

  cyc_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic [3:0] alu_tbl [7] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

  task automatic check_eq(input string tag, input logic [30:0] got, input logic [30:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic cyc_t observe();
    return cyc_t'({STATE, RST_PC, LD_PC, CNT_PC, LD_IR, LD_R3, LD_R2, LD_R1, LD_R0,
                   LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR,
                   IB0_SEL, IB1_SEL, IB2_SEL, ALU_FS, push, pop, ipstksel});
  endfunction

  function automatic cyc_t idle(input logic [2:0] st);
    cyc_t c;
    c = '0;
    c.st = st;
    c.rw = 1'b1;
    return c;
  endfunction

  function automatic cyc_t rst_word();
    cyc_t c;
    c = idle(3'd0);
    c.rst_pc = 1'b1;
    return c;
  endfunction

  // Flags {C,N,V,Z}: codes 1..4 test C..Z directly, 5..8 their complements
  function automatic bit cond_true(input int cc, input logic [3:0] f);
    if (cc == 0) return 1'b1;
    if (cc >= 1 && cc <= 4) return f[4 - cc];
    if (cc >= 5 && cc <= 8) return !f[8 - cc];
    return 1'b0;
  endfunction

  // Expand one instruction into the control words expected on each cycle
  task automatic build(input logic [7:0] iw, input logic [3:0] sr, input logic [9:0] mar);
    int op, ri, rj;
    cyc_t c;
    op = int'(iw[7:4]);
    ri = int'(iw[3:2]);
    rj = int'(iw[1:0]);
    exp_q.delete();
    c = idle(3'd1);
    c.ld_ir = 1'b1; c.cnt_pc = 1'b1; c.ld_ipdr = 1'b1;
    exp_q.push_back(c);
    c = idle(3'd2);
    if (op == 1) begin
      c.ib0 = 2'(rj); c.ld_r[ri] = 1'b1;
    end else if (op == 4) begin
      c.ib0 = 2'(ri); c.push = 1'b1;
    end else if (op == 5) begin
      c.pop = 1'b1; c.ipstk = 1'b1; c.ib2 = 2'd3; c.ld_r[ri] = 1'b1;
    end else if (op >= 6 && op <= 12) begin
      c.ib0 = 2'(ri); c.ib1 = 2'(rj); c.ib2 = 2'd1;
      c.ld_r[ri] = 1'b1; c.ld_sr = 1'b1; c.fs = alu_tbl[op - 6];
    end else if (op == 2 || op == 3 || op == 13) begin
      c.ld_mabr = 1'b1; c.ld_maxr = 1'b1; c.cnt_pc = 1'b1; c.ib0 = 2'(rj);
    end
    exp_q.push_back(c);
    if (op == 2 || op == 3 || op == 13) begin
      c = idle(3'd3);
      c.ld_mar = 1'b1;
      exp_q.push_back(c);
      if (op != 13 || cond_true(int'(iw[3:0]), sr)) begin
        c = idle(3'd4);
        if (op == 2) begin
          c.ld_r[ri] = 1'b1;
          c.ib2 = (mar == IO_A) ? 2'd3 : 2'd2;
        end else if (op == 3) begin
          c.ib0 = 2'(ri);
          if (mar == IO_A) c.ld_opdr = 1'b1;
          else             c.rw = 1'b0;
        end else begin
          c.ld_pc = 1'b1;
        end
        exp_q.push_back(c);
      end
    end
  endtask

  // Entered #1 after the edge that put the DUT into FETCH; leaves likewise
  task automatic run_instr(input string name, input logic [7:0] iw,
                           input logic [3:0] sr, input logic [9:0] mar);
    IW = iw; SR_CNVZ = sr; MARout = mar;
    build(iw, sr, mar);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      check_eq($sformatf("%s iw=%h c%0d", name, iw, i), observe(), exp_q[i]);
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    logic [7:0] riw;
    Reset = 1'b1; IW = 8'h00; SR_CNVZ = 4'h0; MARout = 10'h000;
    repeat (2) @(posedge Clock);
    #1;
    check_eq("reset", observe(), rst_word());
    @(negedge Clock);
    check_eq("reset_hold", observe(), rst_word());
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    run_instr("add",      8'h61, 4'h0,    10'h000);
    run_instr("ld",       8'h29, 4'h0,    10'h010);
    run_instr("st_io",    8'h34, 4'h0,    10'h3FF);
    run_instr("st_mem",   8'h34, 4'h0,    10'h020);
    run_instr("jz_take",  8'hD4, 4'b0001, 10'h055);
    run_instr("jz_skip",  8'hD4, 4'b0000, 10'h055);
    run_instr("push",     8'h44, 4'h0,    10'h000);
    run_instr("pop",      8'h58, 4'h0,    10'h000);
    run_instr("ld_io",    8'h2E, 4'h0,    10'h3FF);
    run_instr("j_never",  8'hD9, 4'hF,    10'h100);
    run_instr("nop",      8'h00, 4'h0,    10'h000);
    run_instr("rsvd",     8'hE7, 4'h0,    10'h000);

    for (int n = 0; n < 300; n++) begin
      riw = 8'($urandom);
      if (riw[7:4] == 4'hF) riw[7:4] = 4'($urandom_range(0, 14));
      run_instr("rand", riw, 4'($urandom),
                ($urandom_range(0, 3) == 0) ? IO_A : 10'($urandom));
    end

    // Reset arriving while an LD sits in its address phase
    IW = 8'h29; SR_CNVZ = 4'h0; MARout = 10'h010;
    build(IW, SR_CNVZ, MARout);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check_eq($sformatf("ld_pre_rst c%0d", i), observe(), exp_q[i]);
      if (i == 2) Reset = 1'b1;
      @(posedge Clock);
      #1;
    end
    check_eq("rst_mid_ld", observe(), rst_word());
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    run_instr("after_rst", 8'h61, 4'h0, 10'h000);

    // HALT parks the core until reset, regardless of inputs
    run_instr("halt", 8'hF0, 4'h0, 10'h000);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check_eq($sformatf("halt_hold %0d", i), observe(), idle(3'd5));
      IW = 8'($urandom); SR_CNVZ = 4'($urandom); MARout = 10'($urandom);
      @(posedge Clock);
      #1;
    end
    IW = 8'hF0;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check_eq("rst_from_halt", observe(), rst_word());
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    run_instr("post_halt", 8'h1B, 4'h0, 10'h000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cjb_risc_hmmiop_cu_v.md
Name: cjb_risc_hmmiop_cu_v

Overview:
Control unit for the 8-bit Harvard memory-mapped-I/O RISC core, directly upstream of the data path. It is a Moore FSM that consumes IW, SR_CNVZ and MARout from the data path and drives every load, select, stack and memory control line back into it. It sequences fetch, decode, address generation and memory phases, one instruction at a time.

Parameters:
IO_ADDR, 10'h3FF, effective address of the memory-mapped I/O port (LD reads IPDR, ST writes OPDR).

Ports:
Clock  in  1  system clock; all state changes on rising edge
Reset  in  1  synchronous, active-high reset
IW  in  8  instruction word from IR; [7:4] opcode, [3:2] Ri, [1:0] Rj/K/cond-low
SR_CNVZ  in  4  status flags {C,N,V,Z}
MARout  in  10  current memory address register
RST_PC, LD_PC, CNT_PC, LD_IR  out  1 each  PC/IR control
LD_R0, LD_R1, LD_R2, LD_R3  out  1 each  register-file loads
LD_SR, LD_MABR, LD_MAXR, LD_MAR  out  1 each  status / address register loads
RW  out  1  DM read(1)/write(0)
LD_IPDR, LD_OPDR  out  1 each  I/O data register loads
IB0_SEL, IB1_SEL, IB2_SEL  out  2 each  bus selects (IB2: 00=IB0, 01=ALU, 10=DM, 11=IP/stack mux)
ALU_FS  out  4  ALU function
push, pop, ipstksel  out  1 each  stack control; ipstksel=1 selects stack, 0 selects IPDR
STATE  out  3  current state, for debug/verification

Behaviour:
- States: S_RST, S_FETCH, S_DECODE, S_ADDR, S_MEM, S_HALT. Outputs are a pure function of state and IW/SR/MARout. Default is all loads 0, RW=1, selects 00, ALU_FS 0000.
- Reset high at a rising edge forces S_RST from any state, mid-instruction included. S_RST asserts only RST_PC (RW=1) and then goes to S_FETCH. After reset, STATE=000 and all outputs hold S_RST values.
- S_FETCH: LD_IR=1, CNT_PC=1, LD_IPDR=1, then S_DECODE.
- S_DECODE, one-word ops (execute, then S_FETCH):
  - 0000 NOP, 1110 reserved: no action.
  - 0001 MOV: IB0_SEL=Rj, IB2_SEL=00, LD_Ri.
  - 0100 PUSH: IB0_SEL=Ri, IB2_SEL=00, push=1.
  - 0101 POP: pop=1, ipstksel=1, IB2_SEL=11, LD_Ri.
  - 0110..1100 ALU: IB0_SEL=Ri, IB1_SEL=Rj, IB2_SEL=01, LD_Ri, LD_SR. ALU_FS: 0110→0000 ADD, 0111→0001 SUB, 1000→0100 AND, 1001→0101 OR, 1010→0110 XOR, 1011→0111 NOT, 1100→1000 ADDK (K=IW[1:0]).
  - 1111 HALT: go to S_HALT.
- S_DECODE, two-word ops (0010 LD, 0011 ST, 1101 JUMP): LD_MABR=1, LD_MAXR=1, CNT_PC=1 (skips the offset byte), IB0_SEL=Rj, IB2_SEL=00, then S_ADDR.
- S_ADDR: LD_MAR=1 (MAR captures on falling edge), then S_MEM. For JUMP, skip S_MEM and go to S_FETCH when the condition is false.
- S_MEM, then S_FETCH:
  - LD: IB2_SEL=10 and LD_Ri. If MARout==IO_ADDR, use IB2_SEL=11 with ipstksel=0 instead.
  - ST: IB0_SEL=Ri, IB2_SEL=00, RW=0. If MARout==IO_ADDR, keep RW=1 and assert LD_OPDR=1 instead.
  - JUMP: LD_PC=1.
- Jump condition IW[3:0]: 0000 always, 0001 C, 0010 N, 0011 V, 0100 Z, 0101 !C, 0110 !N, 0111 !V, 1000 !Z, 1001..1111 never taken.
- S_HALT: all outputs default; stays until Reset.
- LD_Ri one-hot decode of Ri. At most one LD_Rx per cycle; push and pop never asserted together.
- Latency: one-word = 2 cycles; LD/ST = 4; JUMP taken = 4, not taken = 3.

Decomposition:
- Package cjb_risc_cu_pkg holds:
  - opcode constants
  - state encoding (S_RST=000, S_FETCH=001, S_DECODE=010, S_ADDR=011, S_MEM=100, S_HALT=101)
  - IB2 select codes
  - condition codes
  - opcode→ALU_FS lookup
- One sub-module: cjb_cond_eval_v (combinational), with inputs IW[3:0] and SR_CNVZ and output take.

Test Plan:
- Reset, then IW=8'h61 (ADD R0,R1) → STATE 000→001→010. In DECODE: IB0_SEL=00, IB1_SEL=01, IB2_SEL=01, ALU_FS=0000, LD_R0=1, LD_SR=1.
- IW=8'h29 (LD R2,[R1+off]), MARout=10'h010 → DECODE: LD_MABR=LD_MAXR=CNT_PC=1, IB0_SEL=01. ADDR: LD_MAR=1. MEM: IB2_SEL=10, LD_R2=1. 4 cycles total.
- IW=8'h34 (ST R1) with MARout=10'h3FF → MEM: LD_OPDR=1, RW=1. Repeat with MARout=10'h020 → RW=0, LD_OPDR=0.
- IW=8'hD4 (JUMP Z): SR_CNVZ=4'b0001 → LD_PC=1 in MEM. SR_CNVZ=4'b0000 → ADDR returns to FETCH, LD_PC never asserted.
- IW=8'h44 then 8'h58 (PUSH R1, POP R2) → push=1 with IB0_SEL=01; then pop=1, ipstksel=1, IB2_SEL=11, LD_R2=1, push=0.
- IW=8'hF0 → S_HALT held for 10 cycles with no loads; Reset during S_ADDR of an LD → next STATE=000, RST_PC=1, no LD_Rx.
